// File: rtl/ws281x_pkg.sv
// Shared types and constants for the WS281x bit feeder.
package ws281x_pkg;

  localparam int GRB_BITS  = 24;
  localparam int GRBW_BITS = 32;

  // Default latch period, about 80 us at a 50 MHz clock.
  localparam logic [15:0] RST_CNT_DEF = 16'd4000;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    NEXT,
    LATCH
  } state_t;

endpackage

// File: rtl/ws281x_bit_feeder_if.sv
// Pixel-side handshake and encoder-side bit handshake of the WS281x bit feeder.
interface ws281x_bit_feeder_if
  import ws281x_pkg::*;
#(
  parameter int PIX_BITS = GRB_BITS,
  parameter int RST_W    = 16
);
  // Pixel words move on a clock edge where pix_valid_in & pix_ready_out are both
  // high. Once pix_valid_in is raised, the source holds data/last until that edge.
  logic                pix_valid_in;
  logic [PIX_BITS-1:0] pix_data_in;
  logic                pix_last_in;
  logic                pix_ready_out;
  logic [RST_W-1:0]    rst_cnt_in;
  logic                bit_rdy_out;
  logic                bit_data_out;
  logic                bit_done_in;
  logic                frame_done_out;
  logic                busy_out;

  modport slave (
    input  pix_valid_in, pix_data_in, pix_last_in, rst_cnt_in, bit_done_in,
    output pix_ready_out, bit_rdy_out, bit_data_out, frame_done_out, busy_out
  );

  modport master (
    output pix_valid_in, pix_data_in, pix_last_in, rst_cnt_in, bit_done_in,
    input  pix_ready_out, bit_rdy_out, bit_data_out, frame_done_out, busy_out
  );
endinterface

// File: rtl/ws281x_latch_timer.sv
// Loadable down-counter that parks at 1 and flags that terminal value.
module ws281x_latch_timer
  import ws281x_pkg::*;
#(
  parameter int RST_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic [RST_W-1:0] load_val_in,
  input  logic             en_in,
  output logic             tc_out
);
  logic [RST_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      // A zero period still needs one cycle to raise the terminal pulse.
      cnt_d = (load_val_in == '0) ? RST_W'(1) : load_val_in;
    end else if (en_in && (cnt_q > RST_W'(1))) begin
      cnt_d = cnt_q - RST_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_out = (cnt_q == RST_W'(1));

endmodule

// File: rtl/ws281x_bit_feeder.sv
// Serialises pixel words MSB-first into one-bit encoder requests, then
// holds the line idle for the latch period and pulses frame completion.
module ws281x_bit_feeder
  import ws281x_pkg::*;
#(
  parameter int PIX_BITS = GRB_BITS,
  parameter int RST_W    = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ws281x_bit_feeder_if.slave bus,
  output state_t             state_out
);
  localparam int IDX_W = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_BITS - 1);

  state_t              state_q, state_d;
  logic [PIX_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic                pix_ready;
  logic                accept;
  logic                latch_load;
  logic                latch_en;
  logic                latch_tc;

  // Gated by reset so every output reads 0 while reset is held.
  assign pix_ready = ((state_q == IDLE) || (state_q == NEXT)) && !rst_in;
  assign accept    = bus.pix_valid_in && pix_ready;
  assign latch_en  = (state_q == LATCH);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    last_d     = last_q;
    latch_load = 1'b0;
    case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          shift_d = bus.pix_data_in;
          last_d  = bus.pix_last_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bus.bit_done_in) begin
          if (idx_q != LAST_IDX) begin
            shift_d = shift_q << 1;
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end else if (last_q) begin
            latch_load = 1'b1;
            state_d    = LATCH;
          end else begin
            state_d = NEXT;
          end
        end
      end
      LATCH: begin
        if (latch_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  ws281x_latch_timer #(.RST_W(RST_W)) u_latch_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (latch_load),
    .load_val_in (bus.rst_cnt_in),
    .en_in       (latch_en),
    .tc_out      (latch_tc)
  );

  assign bus.pix_ready_out  = pix_ready;
  assign bus.bit_rdy_out    = (state_q == SEND);
  assign bus.bit_data_out   = shift_q[PIX_BITS-1];
  assign bus.frame_done_out = latch_en && latch_tc;
  assign bus.busy_out       = (state_q != IDLE);
  assign state_out          = state_q;

endmodule

// File: tb/tb_ws281x_bit_feeder.sv
// Randomised scoreboard bench for ws281x_bit_feeder with a behavioural encoder.
module tb_ws281x_bit_feeder;
  import ws281x_pkg::*;

  localparam int PB = GRB_BITS;
  localparam int RW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ws281x_bit_feeder_if #(.PIX_BITS(PB), .RST_W(RW)) bus();
  state_t state_dbg;
  logic   enc_done  = 1'b0;
  logic   spur_done = 1'b0;
  assign bus.bit_done_in = enc_done | spur_done;

  ws281x_bit_feeder #(.PIX_BITS(PB), .RST_W(RW)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .bus       (bus),
    .state_out (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  // entry = {first bit of word, final bit of frame, expected bit value}
  logic [2:0] exp_q[$];
  int         acc_q[$];
  int         fd_exp_q[$];
  logic [2:0] mon_e;
  int         last_done_cyc = -100;
  logic       pend_final = 1'b0;
  int         rst_gen = 0;
  int         cur_idx = 0;
  int         rdy_cnt = 0;
  int         fd_cnt = 0;
  logic [PB-1:0] seen_bits = '0;
  bit         enc_spur = 1'b0;
  bit         enc_rand = 1'b0;
  int         enc_delay = 5;
  int         enc_d;
  int         enc_gen;
  logic       enc_cap;
  bit         chk_stream = 1'b0;
  int         stream_acc = 0;
  int         ready_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- encoder model ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      enc_done = 1'b0;
      if (!rst && bus.bit_rdy_out) begin
        enc_gen = rst_gen;
        enc_cap = bus.bit_data_out;
        enc_d   = enc_rand ? int'($urandom_range(6, enc_spur ? 2 : 1)) : enc_delay;
        if (enc_spur) enc_done = 1'b1;
        for (int i = 0; i < enc_d; i++) begin
          @(posedge clk); #1;
          enc_done = 1'b0;
        end
        if (enc_gen == rst_gen && !rst) begin
          check("bit_stable_in_wait", int'(bus.bit_data_out), int'(enc_cap));
          last_done_cyc = cyc;
          if (pend_final)
            fd_exp_q.push_back(cyc + ((bus.rst_cnt_in == '0) ? 1 : int'(bus.rst_cnt_in)));
        end
        enc_done = 1'b1;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst && bus.bit_rdy_out) begin
        rdy_cnt++;
        seen_bits = {seen_bits[PB-2:0], bus.bit_data_out};
        if (exp_q.size() == 0) begin
          check("unexpected_bit_req", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("bit_data", int'(bus.bit_data_out), int'(mon_e[0]));
          pend_final = mon_e[1];
          if (mon_e[2]) begin
            cur_idx = 0;
            if (acc_q.size() == 0) check("first_bit_without_accept", 1, 0);
            else                   check("accept_to_req_latency", cyc, acc_q.pop_front() + 1);
          end else begin
            cur_idx++;
            check("done_to_req_gap", cyc, last_done_cyc + 1);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst && bus.pix_valid_in && bus.pix_ready_out) begin
        acc_q.push_back(cyc);
        if (chk_stream) begin
          if (stream_acc > 0) check("stream_next_accept", cyc, last_done_cyc + 1);
          stream_acc++;
        end
      end
      if (chk_stream && bus.pix_ready_out) ready_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst && bus.frame_done_out) begin
        fd_cnt++;
        if (fd_exp_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else                      check("frame_done_cycle", cyc, fd_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [PB-1:0] w, input bit last, input bit hold);
    logic [2:0] e;
    bit acc;
    int n;
    for (int i = 0; i < PB; i++) begin
      e = {(i == 0), (last && (i == PB - 1)), w[PB-1-i]};
      exp_q.push_back(e);
    end
    bus.pix_valid_in = 1'b1;
    bus.pix_data_in  = w;
    bus.pix_last_in  = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 3000) begin
      acc = bus.pix_ready_out;
      tick(1);
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (!hold) bus.pix_valid_in = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_cnt < target && n < 5000) begin
      tick(1);
      n++;
    end
    if (fd_cnt < target) check("frame_done_timeout", fd_cnt, target);
  endtask

  task automatic wait_state(input state_t s);
    int n;
    n = 0;
    while (state_dbg != s && n < 3000) begin
      tick(1);
      n++;
    end
    if (state_dbg != s) check("state_wait_timeout", int'(state_dbg), int'(s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d required finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int f0;
    int r0;
    int nw;
    int n;
    logic [PB-1:0] w;

    rst = 1'b1;
    bus.pix_valid_in = 1'b0;
    bus.pix_data_in  = '0;
    bus.pix_last_in  = 1'b0;
    bus.rst_cnt_in   = 16'd10;
    tick(3);
    check("rst_pix_ready",   int'(bus.pix_ready_out),  0);
    check("rst_bit_rdy",     int'(bus.bit_rdy_out),    0);
    check("rst_bit_data",    int'(bus.bit_data_out),   0);
    check("rst_frame_done",  int'(bus.frame_done_out), 0);
    check("rst_busy",        int'(bus.busy_out),       0);
    check("rst_state",       int'(state_dbg),          int'(IDLE));
    rst = 1'b0;
    tick(1);
    check("idle_pix_ready",  int'(bus.pix_ready_out),  1);
    check("idle_busy",       int'(bus.busy_out),       0);

    // Spurious done while idle
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(1);
    check("spur_idle_state", int'(state_dbg),       int'(IDLE));
    check("spur_idle_busy",  int'(bus.busy_out),    0);
    check("spur_idle_rdy",   int'(bus.bit_rdy_out), 0);

    // Single known word, fixed encoder latency of 5
    f0 = fd_cnt;
    r0 = rdy_cnt;
    bus.rst_cnt_in = 16'd10;
    enc_delay = 5;
    send_word(24'hA50F81, 1'b1, 1'b0);
    wait_fd(f0 + 1);
    check("single_req_count", rdy_cnt - r0, 24);
    check("single_bit_sequence", int'(seen_bits), int'(24'hA50F81));

    // Three words streamed with valid held high
    f0 = fd_cnt;
    stream_acc = 0;
    ready_cnt  = 0;
    chk_stream = 1'b1;
    send_word(PB'($urandom), 1'b0, 1'b1);
    send_word(PB'($urandom), 1'b0, 1'b1);
    send_word(PB'($urandom), 1'b1, 1'b0);
    wait_fd(f0 + 1);
    chk_stream = 1'b0;
    check("stream_ready_pulses", ready_cnt, 3);
    check("stream_accepts",      stream_acc, 3);

    // Underrun: second word withheld for 50 clocks
    f0 = fd_cnt;
    send_word(PB'($urandom), 1'b0, 1'b0);
    wait_state(NEXT);
    for (int i = 0; i < 50; i++) begin
      spur_done = (i == 20);
      tick(1);
      check("underrun_state", int'(state_dbg),       int'(NEXT));
      check("underrun_rdy",   int'(bus.bit_rdy_out), 0);
      check("underrun_busy",  int'(bus.busy_out),    1);
    end
    spur_done = 1'b0;
    send_word(PB'($urandom), 1'b1, 1'b0);
    wait_fd(f0 + 1);

    // Zero latch period, then period 100 with a mid-latch change
    f0 = fd_cnt;
    bus.rst_cnt_in = 16'd0;
    send_word(PB'($urandom), 1'b1, 1'b0);
    wait_fd(f0 + 1);
    bus.rst_cnt_in = 16'd100;
    send_word(PB'($urandom), 1'b1, 1'b0);
    wait_state(LATCH);
    tick(5);
    bus.rst_cnt_in = 16'd3;
    wait_fd(f0 + 2);

    // Spurious done during every SEND cycle
    f0 = fd_cnt;
    bus.rst_cnt_in = 16'd5;
    enc_spur = 1'b1;
    send_word(PB'($urandom), 1'b1, 1'b0);
    wait_fd(f0 + 1);
    enc_spur = 1'b0;

    // Asynchronous reset while waiting on bit 12
    f0 = fd_cnt;
    bus.rst_cnt_in = 16'd10;
    enc_delay = 5;
    send_word(24'hFFFFFF, 1'b1, 1'b0);
    n = 0;
    while (!(cur_idx == 12 && state_dbg == WAIT) && n < 3000) begin
      tick(1);
      n++;
    end
    check("reached_bit12_wait", int'(cur_idx == 12 && state_dbg == WAIT), 1);
    #2;
    rst = 1'b1;
    rst_gen++;
    exp_q.delete();
    acc_q.delete();
    fd_exp_q.delete();
    #1;
    check("abort_pix_ready",  int'(bus.pix_ready_out),  0);
    check("abort_bit_rdy",    int'(bus.bit_rdy_out),    0);
    check("abort_bit_data",   int'(bus.bit_data_out),   0);
    check("abort_frame_done", int'(bus.frame_done_out), 0);
    check("abort_busy",       int'(bus.busy_out),       0);
    check("abort_state",      int'(state_dbg),          int'(IDLE));
    tick(3);
    rst = 1'b0;
    tick(10);
    check("abort_no_frame_done", fd_cnt, f0);
    send_word(24'h800001, 1'b1, 1'b0);
    wait_fd(f0 + 1);

    // Random frames with random lengths, gaps, latencies and periods
    enc_rand = 1'b1;
    for (int fr = 0; fr < 6; fr++) begin
      f0 = fd_cnt;
      bus.rst_cnt_in = RW'($urandom_range(20, 0));
      enc_spur = ($urandom_range(1, 0) == 1);
      nw = int'($urandom_range(3, 1));
      for (int k = 0; k < nw; k++) begin
        tick(int'($urandom_range(3, 0)));
        w = PB'($urandom);
        send_word(w, (k == nw - 1), 1'b0);
      end
      wait_fd(f0 + 1);
    end
    enc_rand = 1'b0;
    enc_spur = 1'b0;

    tick(5);
    check("exp_bits_drained",  exp_q.size(),    0);
    check("exp_frames_drained", fd_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
